// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake bundle for uart_tx_arbiter: per-requester valid, byte and one-hot ready.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter paced by baud_tick.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit after bit7 (11-period frame).
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  uart_tx_arbiter_if.slave     req_if,
  output logic                 tx,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DATA_W);

`ifdef UART_TX_ARB_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e              state_q, state_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic [IDW-1:0]      last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef UART_TX_ARB_PARITY_EN
  logic                parity_q, parity_d;

  function automatic logic parity_even(input logic [DATA_W-1:0] b);
    return ^b;
  endfunction
`endif

  logic                win_found;
  logic [IDW-1:0]      win_idx;
  logic [DATA_W-1:0]   win_byte;
  int                  cand;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_if.req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  assign win_byte         = req_if.req_data[8*win_idx +: 8];
  assign req_if.req_ready = (state_q == S_IDLE && win_found) ? (NUM_REQ'(1) << win_idx) : '0;

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
`ifdef UART_TX_ARB_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          shift_d      = win_byte;
          grant_id_d   = win_idx;
          last_grant_d = win_idx;
          busy_d       = 1'b1;
          state_d      = S_WAIT;
`ifdef UART_TX_ARB_PARITY_EN
          parity_d     = parity_even(win_byte);
`endif
        end
      end
      // WAIT aligns the start bit to the baud grid; the accept-edge tick is ignored by construction.
      S_WAIT: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_ARB_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state; reset points last_grant at the top index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      grant_id_q   <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Datapath registers are always reloaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
    cnt_q    <= cnt_d;
`ifdef UART_TX_ARB_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset/idle, single frame, round-robin, back-to-back, mid-frame reset.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 2;
  localparam int IDW     = 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           baud_tick = 1'b0;
  logic           tx;
  logic           busy;
  logic [IDW-1:0] grant_id;
  int             n_chk  = 0;
  int             n_pass = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) req_if ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .clk      (clk),
    .reset    (reset),
    .baud_tick(baud_tick),
    .req_if   (req_if.slave),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two quiet clocks, then a one-clock baud pulse; tx is sampled just after the pulse edge.
  task automatic tick();
    step();
    step();
    baud_tick = 1'b1;
    step();
    baud_tick = 1'b0;
  endtask

  task automatic do_reset();
    req_if.req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic accept_one(input string tag, input logic [NUM_REQ-1:0] exp_rdy,
                            input logic [IDW-1:0] exp_id, input logic tick_on_edge);
    #1;
    check({tag, "_ready"}, 32'(req_if.req_ready), 32'(exp_rdy));
    baud_tick = tick_on_edge;
    step();
    baud_tick = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_gid"}, 32'(grant_id), 32'(exp_id));
    check({tag, "_ready_off"}, 32'(req_if.req_ready), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic [IDW-1:0] id);
    logic [7:0] got;
    got = '0;
    step();
    check({tag, "_wait_tx"}, 32'(tx), 32'd1);
    tick();
    check({tag, "_start"}, 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      got[i] = tx;
    end
    check({tag, "_byte"}, 32'(got), 32'(b));
`ifdef UART_TX_ARB_PARITY_EN
    tick();
    check({tag, "_parity"}, 32'(tx), 32'(^b));
`endif
    tick();
    check({tag, "_stop"}, 32'(tx), 32'd1);
    check({tag, "_busy_stop"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_tx_end"}, 32'(tx), 32'd1);
    check({tag, "_gid_end"}, 32'(grant_id), 32'(id));
  endtask

  initial begin
    int bad;
    req_if.req_valid = '0;
    req_if.req_data  = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_ready", 32'(req_if.req_ready), 32'd0);

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || req_if.req_ready !== '0 || grant_id !== '0) bad++;
    end
    check("idle_1000", 32'(bad), 32'd0);

    // Single request; a tick on the accept edge must not start the frame early.
    req_if.req_data  = 16'h0055;
    req_if.req_valid = 2'b01;
    accept_one("single", 2'b01, 1'b0, 1'b1);
    req_if.req_valid = 2'b00;
    req_if.req_data  = 16'h0000;
    run_frame("single", 8'h55, 1'b0);

    // Round-robin with both requesters valid throughout.
    do_reset();
    req_if.req_data  = 16'h3CA5;
    req_if.req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      if (f % 2 == 0) begin
        accept_one("rr0", 2'b01, 1'b0, 1'b0);
        run_frame("rr0", 8'hA5, 1'b0);
      end else begin
        accept_one("rr1", 2'b10, 1'b1, 1'b0);
        run_frame("rr1", 8'h3C, 1'b1);
      end
    end

    // Back-to-back from requester 1 alone: re-accept immediately after STOP.
    do_reset();
    req_if.req_data  = 16'hC300;
    req_if.req_valid = 2'b10;
    accept_one("b2b_a", 2'b10, 1'b1, 1'b0);
    run_frame("b2b_a", 8'hC3, 1'b1);
    accept_one("b2b_b", 2'b10, 1'b1, 1'b0);
    run_frame("b2b_b", 8'hC3, 1'b1);

    // Reset during bit3 of 0xFF; afterwards requester 0 must win again.
    do_reset();
    req_if.req_data  = 16'h81FF;
    req_if.req_valid = 2'b01;
    accept_one("mid", 2'b01, 1'b0, 1'b0);
    req_if.req_valid = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    check("mid_bit3", 32'(tx), 32'd1);
    check("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    accept_one("post", 2'b01, 1'b0, 1'b0);
    run_frame("post", 8'hFF, 1'b0);

`ifdef UART_TX_ARB_PARITY_EN
    do_reset();
    req_if.req_data  = 16'h0007;
    req_if.req_valid = 2'b01;
    accept_one("par07", 2'b01, 1'b0, 1'b0);
    run_frame("par07", 8'h07, 1'b0);
    req_if.req_data  = 16'h0003;
    accept_one("par03", 2'b01, 1'b0, 1'b0);
    run_frame("par03", 8'h03, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit line between NUM_REQ byte requesters using round-robin arbitration.
- Serialises the granted byte as an 8N1 frame (optional parity), one bit per baud_tick pulse from baud_gen.
- Sits between client logic (console, debug, status) and the board TX pin.
- baud_gen supplies the bit timing; this block decides who transmits and when.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- IDW, $clog2(NUM_REQ) (min 1): width of grant_id.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- baud_tick  in  1  one-clk pulse per bit period, from baud_gen.
- req_valid  in  NUM_REQ  bit i: requester i holds a byte.
- req_data  in  NUM_REQ*8  byte i at bits [8*i+7:8*i].
- req_ready  out  NUM_REQ  one-hot accept; transfer when valid[i]&ready[i] at a clk edge.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high from byte accept until the frame completes.
- grant_id  out  IDW  index of the requester owning the current or last frame.

Behaviour:
- Reset, which wins over all other inputs on that edge:
  - state=IDLE, tx=1, busy=0, grant_id=0, req_ready=0.
  - RR pointer set so requester 0 has highest priority.
- States: IDLE, WAIT, START, DATA, [PARITY], STOP.
- IDLE:
  - req_ready is combinational: one-hot on the winner when state==IDLE and any req_valid is set; otherwise all 0.
  - Winner is the first valid index searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - On an edge with a winner: latch the byte into a shift register, grant_id<=winner, last_grant<=winner, busy<=1, go to WAIT.
  - Zero-cycle accept latency.
- WAIT: hold tx=1. On the next baud_tick: tx<=0, go to START. A baud_tick on the accept edge itself is not counted.
- START: on baud_tick: tx<=bit0, go to DATA with bit count 0.
- DATA:
  - On each baud_tick: shift right, tx<=next bit, count+1.
  - When the 8th bit period ends: tx<=parity (if enabled, go to PARITY), otherwise tx<=1 and go to STOP.
- PARITY: on baud_tick: tx<=1, go to STOP.
- STOP: on baud_tick: go to IDLE, busy<=0. tx stays 1.
- Bit order: LSB first. Each bit is held for exactly one baud period (baud_tick to baud_tick).
- Frame length: 10 baud periods without parity, 11 with parity.
- Back-to-back frames:
  - IDLE can accept on the cycle after STOP completes.
  - The minimum idle gap is the WAIT interval, which is under one baud period.
- Requester behaviour:
  - req_valid or req_data changing while busy: ignored. Requesters must hold their byte until they see ready.
  - A requester dropping valid before grant: no effect.
- Reset mid-frame: tx returns to 1 on that edge. The frame is aborted and the latched byte is discarded; it is not re-requested.
- baud_tick held high across several clks: each high clk counts as a tick. Well-formed baud_gen pulses are exactly one clk wide.
- No valid requests: stays in IDLE, tx=1, grant_id keeps its last value.

Optional Feature:
- Macro: UART_TX_ARB_PARITY_EN.
- Defined:
  - PARITY state is compiled in. Parity bit = XOR of the 8 data bits (even parity), sent after bit7.
  - Frame is 11 periods.
- Undefined:
  - No PARITY state. Frame is 10 periods; STOP follows bit7 directly.

Test Plan:
- Reset then idle: no valid for 1000 clks -> tx=1, busy=0, req_ready=0, grant_id=0 throughout.
- Single request:
  - req_valid[0]=1, data 0x55 -> req_ready[0] high for exactly 1 clk; grant_id=0; busy=1.
  - Line samples at each baud_tick: 0, then 1,0,1,0,1,0,1,0, then 1 (stop).
  - busy falls at the 10th tick after start, or the 11th with parity (bit 0 for 0x55).
- Round-robin, NUM_REQ=2, both valid continuously, data0=0xA5, data1=0x3C:
  - Grants alternate 0,1,0,1.
  - Line decodes to A5,3C,A5,3C; no requester is granted twice in a row.
- Back-to-back: requester 1 reasserts immediately after accept -> next accept on the clk after STOP ends; no frame overlap; tx never low in the idle gap.
- Reset mid-frame: assert reset during bit3 of 0xFF -> tx=1 and busy=0 on the next edge; afterwards requester 0 wins over requester 1 when both are valid.
- Parity (macro defined): 0x07 -> parity bit 1; 0x03 -> parity bit 0; stop bit at the 10th data-relative tick.
